// File: rtl/sd_spi_master.sv
// ---------------------------------------------------------------------------
// sd_spi_master
//
// SPI mode-0 byte master for the emulated SD card. Bytes are offered on a
// valid/ready port and shifted out MSB first on mosi while the same number of
// bits is clocked in from miso. The received byte is presented on rx_data
// with a one-clock rx_valid pulse. sck is a divided clk_spi whose half-period
// is clk_div+1 clocks (clk_div of 0 behaves like 1), so the card side always
// sees at least four clk_spi cycles per sck period.
//
// Optional feature macro: SDSPI_CRC16_EN
//   defined     : crc16 runs CRC16-CCITT (poly 0x1021, init 0, MSB first)
//                 over every sampled miso bit; crc_clr clears it and wins
//                 over a simultaneous sample.
//   not defined : crc16 is tied to 0000 and crc_clr is ignored.
//
// Ports
//   clk_spi   in   block clock
//   reset     in   synchronous, active-high reset
//   clk_div   in   sck half-period minus one, sampled at byte accept
//   cs_req    in   1 = select the card (ss driven low while idle)
//   tx_data   in   byte to shift out, MSB first
//   tx_valid  in   byte offered
//   tx_ready  out  high while idle; a byte is accepted on tx_valid & tx_ready
//   rx_data   out  last completed received byte
//   rx_valid  out  one-clock pulse when rx_data updates
//   busy      out  a byte is in flight
//   crc_clr   in   clear crc16 (CRC feature only)
//   crc16     out  running CRC of received bits
//   ss        out  chip select, active-low
//   sck       out  SPI clock, idles low
//   mosi      out  serial data out
//   miso      in   serial data in
// ---------------------------------------------------------------------------
module sd_spi_master #(
   parameter int DIV_W = 8
) (
   input  logic             clk_spi,
   input  logic             reset,
   input  logic [DIV_W-1:0] clk_div,
   input  logic             cs_req,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             busy,
   input  logic             crc_clr,
   output logic [15:0]      crc16,
   output logic             ss,
   output logic             sck,
   output logic             mosi,
   input  logic             miso
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_ss;
   logic [7:0]       r_txShift;
   logic [7:0]       r_rxShift;
   logic [7:0]       r_rxData;
   logic             r_rxValid;
   logic [2:0]       r_bitCnt;
   logic [DIV_W-1:0] r_halfCnt;
   logic [DIV_W-1:0] r_halfLoad;

   state_t           w_stateNext;
   logic             w_ssNext;
   logic [7:0]       w_txShiftNext;
   logic [7:0]       w_rxShiftNext;
   logic [7:0]       w_rxDataNext;
   logic             w_rxValidNext;
   logic [2:0]       w_bitCntNext;
   logic [DIV_W-1:0] w_halfCntNext;
   logic [DIV_W-1:0] w_halfLoadNext;
   logic             w_sample;
   logic [DIV_W-1:0] w_halfInit;

   // The half-period reload value is H-1. A divider of 0 would give a
   // one-clock half-period, too fast for the card emulator, so it is
   // promoted to 1 before being latched.
   assign w_halfInit = (clk_div == '0) ? DIV_W'(1) : clk_div;

   // State and datapath registers. Everything returns to the idle, deselected
   // condition on reset, which also throws away a byte that was in flight.
   always_ff @(posedge clk_spi) begin
      if (reset) begin
         r_state    <= IDLE;
         r_ss       <= 1'b1;
         r_txShift  <= 8'hFF;
         r_rxShift  <= 8'h00;
         r_rxData   <= 8'h00;
         r_rxValid  <= 1'b0;
         r_bitCnt   <= 3'd0;
         r_halfCnt  <= '0;
         r_halfLoad <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_ss       <= w_ssNext;
         r_txShift  <= w_txShiftNext;
         r_rxShift  <= w_rxShiftNext;
         r_rxData   <= w_rxDataNext;
         r_rxValid  <= w_rxValidNext;
         r_bitCnt   <= w_bitCntNext;
         r_halfCnt  <= w_halfCntNext;
         r_halfLoad <= w_halfLoadNext;
      end
   end

   // Next-state logic. Each SHIFT state lasts exactly H clocks, counted down
   // from H-1 in r_halfCnt. The rising edge samples miso into the receive
   // shifter; the falling edge advances mosi to the next bit or, after the
   // eighth bit, publishes the received byte and returns to IDLE. Chip select
   // only follows cs_req while idle so a byte is never cut in half.
   always_comb begin
      w_stateNext    = r_state;
      w_ssNext       = r_ss;
      w_txShiftNext  = r_txShift;
      w_rxShiftNext  = r_rxShift;
      w_rxDataNext   = r_rxData;
      w_rxValidNext  = 1'b0;
      w_bitCntNext   = r_bitCnt;
      w_halfCntNext  = r_halfCnt;
      w_halfLoadNext = r_halfLoad;
      w_sample       = 1'b0;

      case (r_state)
         IDLE: begin
            w_ssNext = ~cs_req;
            if (tx_valid) begin
               w_txShiftNext  = tx_data;
               w_rxShiftNext  = 8'h00;
               w_halfLoadNext = w_halfInit;
               w_halfCntNext  = w_halfInit;
               w_bitCntNext   = 3'd7;
               w_stateNext    = SHIFT_LO;
            end
         end

         SHIFT_LO: begin
            if (r_halfCnt == '0) begin
               w_halfCntNext = r_halfLoad;
               w_rxShiftNext = {r_rxShift[6:0], miso};
               w_sample      = 1'b1;
               w_stateNext   = SHIFT_HI;
            end else begin
               w_halfCntNext = r_halfCnt - DIV_W'(1);
            end
         end

         SHIFT_HI: begin
            if (r_halfCnt == '0) begin
               w_halfCntNext = r_halfLoad;
               if (r_bitCnt == 3'd0) begin
                  w_rxDataNext  = r_rxShift;
                  w_rxValidNext = 1'b1;
                  w_stateNext   = IDLE;
               end else begin
                  w_bitCntNext  = r_bitCnt - 3'd1;
                  w_txShiftNext = {r_txShift[6:0], 1'b1};
                  w_stateNext   = SHIFT_LO;
               end
            end else begin
               w_halfCntNext = r_halfCnt - DIV_W'(1);
            end
         end

         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Line outputs are decoded from the registered state so they change only
   // on clock edges: sck is high exactly while in SHIFT_HI, and mosi rests
   // high whenever no byte is being shifted.
   assign tx_ready = (r_state == IDLE);
   assign busy     = ~tx_ready;
   assign sck      = (r_state == SHIFT_HI);
   assign mosi     = (r_state == IDLE) ? 1'b1 : r_txShift[7];
   assign ss       = r_ss;
   assign rx_data  = r_rxData;
   assign rx_valid = r_rxValid;

`ifdef SDSPI_CRC16_EN
   logic [15:0] r_crc;
   logic        w_crcFeedback;

   assign w_crcFeedback = r_crc[15] ^ miso;

   // Bit-serial CRC16-CCITT over the received stream, advanced in the same
   // cycle the bit is sampled. A clear request takes precedence so software
   // can restart the CRC exactly at a block boundary.
   always_ff @(posedge clk_spi) begin
      if (reset) begin
         r_crc <= 16'h0000;
      end else if (crc_clr) begin
         r_crc <= 16'h0000;
      end else if (w_sample) begin
         r_crc <= {r_crc[14:0], 1'b0} ^ (w_crcFeedback ? 16'h1021 : 16'h0000);
      end
   end

   assign crc16 = r_crc;
`else
   logic w_unusedCrcClr;
   logic w_unusedSample;

   // Without the CRC feature the clear input and the sample strobe have no
   // consumer; they are tied off here and crc16 is held at zero.
   assign w_unusedCrcClr = crc_clr;
   assign w_unusedSample = w_sample;
   assign crc16          = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_spi_master.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_master
//
// Self-checking bench for sd_spi_master. A timing model derived from the
// cycle formulas of the SPI byte transfer (accept at cycle A, k-th rise at
// A+1+(2k-1)H, k-th fall at A+1+2kH, completion at A+1+16H) predicts every
// output on every cycle; a handful of literal expectations pin the model.
// Honours SDSPI_CRC16_EN to decide what crc16 must read.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_spi_master;

   localparam int DIV_W = 8;

   logic             clk_spi;
   logic             reset;
   logic [DIV_W-1:0] clk_div;
   logic             cs_req;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             busy;
   logic             crc_clr;
   logic [15:0]      crc16;
   logic             ss;
   logic             sck;
   logic             mosi;
   logic             miso;

   int   nChecks = 0;
   int   nPass   = 0;
   int   cyc     = 0;

   int   misoMode   = 0;
   logic misoRand   = 1'b0;
   logic crcClrMan  = 1'b0;
   logic crcClrRand = 1'b0;
   logic randCrc    = 1'b0;

   // miso source: 0 = loopback of mosi, 1 = random per cycle, 2 = constant 1
   assign miso    = (misoMode == 0) ? mosi : ((misoMode == 1) ? misoRand : 1'b1);
   assign crc_clr = crcClrMan | crcClrRand;

   sd_spi_master #(.DIV_W(DIV_W)) dut (
      .clk_spi  (clk_spi),
      .reset    (reset),
      .clk_div  (clk_div),
      .cs_req   (cs_req),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .crc_clr  (crc_clr),
      .crc16    (crc16),
      .ss       (ss),
      .sck      (sck),
      .mosi     (mosi),
      .miso     (miso)
   );

   // Free-running clock and cycle counter; cycle c starts at posedge c.
   initial clk_spi = 1'b0;
   always #5 clk_spi = ~clk_spi;
   always @(posedge clk_spi) cyc <= cyc + 1;

   // Background random sources for miso and crc_clr.
   initial begin
      forever begin
         @(posedge clk_spi);
         #1;
         misoRand   = 1'($urandom_range(0, 1));
         crcClrRand = randCrc && ($urandom_range(0, 15) == 0);
      end
   end

   // Hang guard.
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual === expected) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // ---------------- behavioural model + per-cycle compare -----------------
   logic        modelOn   = 1'b0;
   logic        mInFlight = 1'b0;
   int          mA        = 0;
   int          mH        = 2;
   logic [7:0]  mTx       = 8'h00;
   logic [7:0]  mRxShift  = 8'h00;
   logic [7:0]  mRxData   = 8'h00;
   logic        mSs       = 1'b1;
   logic [15:0] mCrc      = 16'h0000;

   always @(negedge clk_spi) begin
      int          t;
      int          bitIdx;
      logic        act;
      logic        done;
      logic        sample;
      logic        eSck;
      logic        eMosi;
      logic [7:0]  eRx;
      logic [29:0] expVec;
      logic [29:0] actVec;

      t      = cyc - mA;
      act    = mInFlight && (t >= 1) && (t <= 16 * mH);
      done   = mInFlight && (t == 16 * mH + 1);
      eSck   = 1'b0;
      eMosi  = 1'b1;
      if (act) begin
         eSck   = (((t - 1) / mH) % 2) == 1;
         bitIdx = 7 - ((t - 1) / (2 * mH));
         eMosi  = mTx[bitIdx];
      end
      eRx    = done ? mRxShift : mRxData;
      expVec = {mSs, eSck, eMosi, ~act, act, done, eRx, mCrc};
      actVec = {ss, sck, mosi, tx_ready, busy, rx_valid, rx_data, crc16};
      if (modelOn) checkOutput($sformatf("model@cycle%0d", cyc), 32'(actVec), 32'(expVec));

      if (done) begin
         mRxData   = mRxShift;
         mInFlight = 1'b0;
      end
      sample = act && ((t % mH) == 0) && (((t / mH) % 2) == 1);
      if (sample) mRxShift = {mRxShift[6:0], miso};
`ifdef SDSPI_CRC16_EN
      if (crc_clr) mCrc = 16'h0000;
      else if (sample) mCrc = crcStep(mCrc, miso);
`endif

      if (reset) begin
         modelOn   = 1'b1;
         mInFlight = 1'b0;
         mSs       = 1'b1;
         mRxData   = 8'h00;
         mCrc      = 16'h0000;
      end else begin
         if (!act) begin
            mSs = ~cs_req;
            if (tx_valid) begin
               mInFlight = 1'b1;
               mA        = cyc;
               mH        = ((clk_div == 0) ? 1 : int'(clk_div)) + 1;
               mTx       = tx_data;
               mRxShift  = 8'h00;
            end
         end
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic nextCycle();
      @(posedge clk_spi);
      #1;
   endtask

   // Offer a byte and hold it until accepted; returns the accept cycle.
   task automatic applyStimulus(input logic [7:0] data, input logic [DIV_W-1:0] div, output int acceptCyc);
      bit got;
      got       = 1'b0;
      acceptCyc = -1;
      tx_data   = data;
      clk_div   = div;
      tx_valid  = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk_spi);
         if (tx_ready) begin
            got       = 1'b1;
            acceptCyc = cyc;
         end
         nextCycle();
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      clk_div  = DIV_W'($urandom);
      if (!got) checkOutput("acceptTimeout", 32'd0, 32'd1);
   endtask

   // Wait for rx_valid; returns its cycle and data, ending just after a posedge.
   task automatic waitRx(input int bound, output int rxCyc, output logic [7:0] data);
      bit got;
      got   = 1'b0;
      rxCyc = -1;
      data  = 8'h00;
      for (int i = 0; i < bound && !got; i++) begin
         @(negedge clk_spi);
         if (rx_valid) begin
            got   = 1'b1;
            rxCyc = cyc;
            data  = rx_data;
         end
         nextCycle();
      end
      if (!got) checkOutput("rxTimeout", 32'd0, 32'd1);
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      int         a;
      int         rc;
      int         rx1;
      int         rx2;
      int         rxCount;
      logic [7:0] d;
      logic [7:0] rd1;
      logic [7:0] rd2;

      reset    = 1'b1;
      clk_div  = '0;
      cs_req   = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;

      // Reset for two clocks.
      nextCycle();
      nextCycle();
      reset = 1'b0;
      @(negedge clk_spi);
      checkOutput("resetState", 32'({ss, sck, mosi, tx_ready, busy, rx_valid, rx_data, crc16}),
                  32'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000}));
      nextCycle();

      // Loopback A5 with clk_div=1.
      misoMode = 0;
      applyStimulus(8'hA5, DIV_W'(1), a);
      waitRx(100, rc, d);
      checkOutput("a5Latency", 32'(rc - a), 32'd33);
      checkOutput("a5Data", 32'(d), 32'h0000_00A5);

      // Back-to-back 3C/C3 with clk_div=0 and a mid-byte cs_req change.
      cs_req = 1'b1;
      nextCycle();
      nextCycle();
      tx_data  = 8'h3C;
      clk_div  = '0;
      tx_valid = 1'b1;
      @(negedge clk_spi);
      a   = cyc;
      rx1 = -1;
      rx2 = -1;
      rd1 = 8'h00;
      rd2 = 8'h00;
      for (int t = 1; t <= 70; t++) begin
         nextCycle();
         if (t == 1)  tx_data  = 8'hC3;
         if (t == 10) cs_req   = 1'b0;
         if (t == 34) tx_valid = 1'b0;
         @(negedge clk_spi);
         if (rx_valid && rx1 < 0) begin
            rx1 = t;
            rd1 = rx_data;
         end else if (rx_valid) begin
            rx2 = t;
            rd2 = rx_data;
         end
         if (t == 33) checkOutput("ssHeldMidByte", 32'(ss), 32'd0);
         if (t == 34) checkOutput("ssAfterByte", 32'(ss), 32'd1);
      end
      nextCycle();
      checkOutput("b2bFirstRx", 32'(rx1), 32'd33);
      checkOutput("b2bSecondRx", 32'(rx2), 32'd66);
      checkOutput("b2bFirstData", 32'(rd1), 32'h3C);
      checkOutput("b2bSecondData", 32'(rd2), 32'hC3);

      // Randomized traffic checked by the model.
      misoMode = 1;
      randCrc  = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            cs_req = 1'($urandom_range(0, 1));
            nextCycle();
         end
         applyStimulus(8'($urandom), DIV_W'($urandom_range(0, 4)), a);
         if ($urandom_range(0, 1) == 1) waitRx(200, rc, d);
      end
      waitRx(200, rc, d);
      randCrc = 1'b0;
      nextCycle();

      // Reset in the middle of a byte.
      misoMode = 0;
      cs_req   = 1'b1;
      applyStimulus(8'h81, DIV_W'(3), a);
      while (cyc < a + 20) nextCycle();
      reset = 1'b1;
      nextCycle();
      reset = 1'b0;
      @(negedge clk_spi);
      checkOutput("resetMidSck", 32'(sck), 32'd0);
      checkOutput("resetMidSs", 32'(ss), 32'd1);
      rxCount = 0;
      for (int i = 0; i < 80; i++) begin
         nextCycle();
         @(negedge clk_spi);
         if (rx_valid) rxCount++;
      end
      nextCycle();
      checkOutput("resetNoRxValid", 32'(rxCount), 32'd0);
      applyStimulus(8'h5A, DIV_W'(3), a);
      waitRx(200, rc, d);
      checkOutput("postResetLatency", 32'(rc - a), 32'd65);
      checkOutput("postResetData", 32'(d), 32'h5A);

      // CRC over 512 bytes of FF with miso held high.
      misoMode  = 2;
      crcClrMan = 1'b1;
      nextCycle();
      crcClrMan = 1'b0;
      for (int n = 0; n < 512; n++) begin
         applyStimulus(8'hFF, DIV_W'(1), a);
         waitRx(100, rc, d);
      end
      @(negedge clk_spi);
`ifdef SDSPI_CRC16_EN
      checkOutput("crc512FF", 32'(crc16), 32'h7FA1);
`else
      checkOutput("crcDisabled", 32'(crc16), 32'h0000);
`endif
      nextCycle();

      // Clear coincident with a sample cycle (first sample at A+2 for H=2).
      applyStimulus(8'hFF, DIV_W'(1), a);
      nextCycle();
      crcClrMan = 1'b1;
      nextCycle();
      crcClrMan = 1'b0;
      @(negedge clk_spi);
      checkOutput("crcClrPriority", 32'(crc16), 32'h0000);
      nextCycle();
      waitRx(100, rc, d);
      checkOutput("crcByteData", 32'(d), 32'hFF);

      nextCycle();
      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
